// File: rtl/wb_uart_pkg.sv
// Shared constants for the wishbone UART: register addresses, IIR codes,
// LSR/IER bit positions and the serial state encodings.
package wb_uart_pkg;

    localparam logic [2:0] REG_RBR = 3'd0;
    localparam logic [2:0] REG_IER = 3'd1;
    localparam logic [2:0] REG_IIR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_MCR = 3'd4;
    localparam logic [2:0] REG_LSR = 3'd5;
    localparam logic [2:0] REG_MSR = 3'd6;
    localparam logic [2:0] REG_SCR = 3'd7;

    localparam logic [7:0] IIR_NONE = 8'h01;
    localparam logic [7:0] IIR_THRE = 8'h02;
    localparam logic [7:0] IIR_RDA  = 8'h04;
    localparam logic [7:0] IIR_RLS  = 8'h06;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam int IER_RDA  = 0;
    localparam int IER_THRE = 1;
    localparam int IER_RLS  = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

endpackage

// File: rtl/wb_uart_fifo.sv
// Byte-wide synchronous FIFO with clear; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module wb_uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == DEPTH[AW:0]);
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);
    assign o_data   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_doPush} - {{AW{1'b0}}, w_doPop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_doPush && !i_clear) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone slave UART with a 16550-style register map, 8N1 framing,
// 16x oversampling from a programmable divisor and one level interrupt.
module wb_uart_lite
    import wb_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_RESET  = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        int_o,
    output logic        stx_pad_o,
    input  logic        srx_pad_i,
    output logic        rts_pad_o,
    input  logic        cts_pad_i,
    output logic        dtr_pad_o,
    input  logic        dsr_pad_i,
    input  logic        ri_pad_i,
    input  logic        dcd_pad_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        r_ack;
    logic [7:0]  r_lcr;
    logic [2:0]  r_ier;
    logic [4:0]  r_mcr;
    logic [7:0]  r_scr;
    logic [7:0]  r_dll;
    logic [7:0]  r_dlm;
    logic        r_threMask;
    logic        r_oe;
    logic        r_fe;
    logic        r_int;
    logic [15:0] r_baudCnt;

    logic [2:0]  w_adr;
    logic [7:0]  w_wbyte;
    logic        w_dlab;
    logic        w_loop;
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_thrWrite;
    logic        w_dllWrite;
    logic        w_dlmWrite;
    logic        w_ierWrite;
    logic        w_fcrWrite;
    logic        w_rbrRead;
    logic        w_iirRead;
    logic        w_lsrRead;
    logic        w_rxClear;
    logic        w_txClear;
    logic [15:0] w_div;
    logic        w_tick;
    logic [7:0]  w_iir;
    logic [7:0]  w_lsr;
    logic [7:0]  w_msr;
    logic [7:0]  w_rdByte;

    logic [7:0]    w_rxData;
    logic          w_rxFull;
    logic          w_rxEmpty;
    logic [CW-1:0] w_rxCount;
    logic [7:0]    w_txData;
    logic          w_txFull;
    logic          w_txEmpty;
    logic [CW-1:0] w_txCount;
    logic          w_txAvail;

    txState_t    r_txState;
    txState_t    w_txStateNext;
    logic [3:0]  r_txTicks;
    logic [3:0]  w_txTicksNext;
    logic [2:0]  r_txBits;
    logic [2:0]  w_txBitsNext;
    logic [7:0]  r_txShift;
    logic [7:0]  w_txShiftNext;
    logic        r_txLine;
    logic        w_txLineNext;
    logic        w_txPop;

    rxState_t    r_rxState;
    rxState_t    w_rxStateNext;
    logic [3:0]  r_rxTicks;
    logic [3:0]  w_rxTicksNext;
    logic [2:0]  r_rxBits;
    logic [2:0]  w_rxBitsNext;
    logic [7:0]  r_rxShift;
    logic [7:0]  w_rxShiftNext;
    logic [1:0]  r_rxSync;
    logic        r_rxPrev;
    logic        w_rxSerial;
    logic        w_rxIn;
    logic        w_rxFall;
    logic        w_rxPush;
    logic        w_rxStopBad;

    logic        w_unused;

    assign w_adr    = wb_adr_i[2:0];
    assign w_wbyte  = wb_dat_i[7:0];
    assign w_dlab   = r_lcr[7];
    assign w_loop   = r_mcr[4];
    assign w_access = r_ack & wb_cyc_i & wb_stb_i;
    assign w_wr     = w_access & wb_we_i & wb_sel_i[0];
    assign w_rd     = w_access & ~wb_we_i;

    assign w_thrWrite = w_wr & (w_adr == REG_RBR) & ~w_dlab;
    assign w_dllWrite = w_wr & (w_adr == REG_RBR) & w_dlab;
    assign w_dlmWrite = w_wr & (w_adr == REG_IER) & w_dlab;
    assign w_ierWrite = w_wr & (w_adr == REG_IER) & ~w_dlab;
    assign w_fcrWrite = w_wr & (w_adr == REG_IIR);
    assign w_rbrRead  = w_rd & (w_adr == REG_RBR) & ~w_dlab;
    assign w_iirRead  = w_rd & (w_adr == REG_IIR);
    assign w_lsrRead  = w_rd & (w_adr == REG_LSR);
    assign w_rxClear  = w_fcrWrite & w_wbyte[1];
    assign w_txClear  = w_fcrWrite & w_wbyte[2];

    assign w_unused = &{1'b0, wb_adr_i[4:3], wb_dat_i[31:8], wb_sel_i[3:1],
                        w_rxCount, w_txCount, w_txFull};

    // Ack is a one-cycle pulse; ack itself blocks a second ack on the next cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_ack <= 1'b0;
        else          r_ack <= wb_cyc_i & wb_stb_i & ~r_ack;
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = {24'h0, w_rdByte};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_lcr      <= 8'h00;
            r_ier      <= 3'b000;
            r_mcr      <= 5'b00000;
            r_scr      <= 8'h00;
            r_dll      <= DIV_RESET[7:0];
            r_dlm      <= DIV_RESET[15:8];
            r_threMask <= 1'b0;
        end else begin
            if (w_wr && w_adr == REG_LCR) r_lcr <= w_wbyte;
            if (w_wr && w_adr == REG_MCR) r_mcr <= w_wbyte[4:0];
            if (w_wr && w_adr == REG_SCR) r_scr <= w_wbyte;
            if (w_ierWrite) r_ier <= w_wbyte[2:0];
            if (w_dllWrite) r_dll <= w_wbyte;
            if (w_dlmWrite) r_dlm <= w_wbyte;
            if (w_thrWrite || (w_ierWrite && !r_ier[IER_THRE] && w_wbyte[IER_THRE]))
                r_threMask <= 1'b0;
            else if (w_iirRead && w_iir == IIR_THRE)
                r_threMask <= 1'b1;
        end
    end

    assign w_div  = {r_dlm, r_dll};
    assign w_tick = (w_div != 16'd0) && (r_baudCnt <= 16'd1);

    // Divisor writes restart the count from the new value so the next tick is a full period away.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)            r_baudCnt <= DIV_RESET[15:0];
        else if (w_dllWrite)     r_baudCnt <= {r_dlm, w_wbyte};
        else if (w_dlmWrite)     r_baudCnt <= {w_wbyte, r_dll};
        else if (w_tick)         r_baudCnt <= w_div;
        else if (r_baudCnt != 0) r_baudCnt <= r_baudCnt - 16'd1;
    end

    wb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxFifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_clear (w_rxClear),
        .i_push  (w_rxPush),
        .i_data  (r_rxShift),
        .i_pop   (w_rbrRead),
        .o_data  (w_rxData),
        .o_full  (w_rxFull),
        .o_empty (w_rxEmpty),
        .o_count (w_rxCount)
    );

    wb_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txFifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_clear (w_txClear),
        .i_push  (w_thrWrite),
        .i_data  (w_wbyte),
        .i_pop   (w_txPop),
        .o_data  (w_txData),
        .o_full  (w_txFull),
        .o_empty (w_txEmpty),
        .o_count (w_txCount)
    );

    assign w_txAvail = ~w_txEmpty & ~w_txClear;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_txState <= TX_IDLE;
            r_txTicks <= 4'd0;
            r_txBits  <= 3'd0;
            r_txShift <= 8'h00;
            r_txLine  <= 1'b1;
        end else begin
            r_txState <= w_txStateNext;
            r_txTicks <= w_txTicksNext;
            r_txBits  <= w_txBitsNext;
            r_txShift <= w_txShiftNext;
            r_txLine  <= w_txLineNext;
        end
    end

    // The stop bit flows straight into the next start bit when more data is queued.
    always_comb begin
        w_txStateNext = r_txState;
        w_txTicksNext = r_txTicks;
        w_txBitsNext  = r_txBits;
        w_txShiftNext = r_txShift;
        w_txLineNext  = r_txLine;
        w_txPop       = 1'b0;
        case (r_txState)
            TX_IDLE: begin
                w_txTicksNext = 4'd0;
                if (w_tick && w_txAvail) begin
                    w_txPop       = 1'b1;
                    w_txShiftNext = w_txData;
                    w_txLineNext  = 1'b0;
                    w_txStateNext = TX_START;
                end
            end
            TX_START: if (w_tick) begin
                w_txTicksNext = r_txTicks + 4'd1;
                if (r_txTicks == 4'd15) begin
                    w_txStateNext = TX_DATA;
                    w_txBitsNext  = 3'd0;
                    w_txLineNext  = r_txShift[0];
                end
            end
            TX_DATA: if (w_tick) begin
                w_txTicksNext = r_txTicks + 4'd1;
                if (r_txTicks == 4'd15) begin
                    if (r_txBits == 3'd7) begin
                        w_txStateNext = TX_STOP;
                        w_txLineNext  = 1'b1;
                    end else begin
                        w_txBitsNext  = r_txBits + 3'd1;
                        w_txShiftNext = {1'b0, r_txShift[7:1]};
                        w_txLineNext  = r_txShift[1];
                    end
                end
            end
            TX_STOP: if (w_tick) begin
                w_txTicksNext = r_txTicks + 4'd1;
                if (r_txTicks == 4'd15) begin
                    if (w_txAvail) begin
                        w_txPop       = 1'b1;
                        w_txShiftNext = w_txData;
                        w_txLineNext  = 1'b0;
                        w_txStateNext = TX_START;
                    end else begin
                        w_txLineNext  = 1'b1;
                        w_txStateNext = TX_IDLE;
                    end
                end
            end
            default: w_txStateNext = TX_IDLE;
        endcase
    end

    assign w_rxSerial = w_loop ? r_txLine : srx_pad_i;
    assign w_rxIn     = r_rxSync[1];
    assign w_rxFall   = r_rxPrev & ~w_rxIn;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rxSync <= 2'b11;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxSync <= {r_rxSync[0], w_rxSerial};
            r_rxPrev <= w_rxIn;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rxState <= RX_IDLE;
            r_rxTicks <= 4'd0;
            r_rxBits  <= 3'd0;
            r_rxShift <= 8'h00;
        end else begin
            r_rxState <= w_rxStateNext;
            r_rxTicks <= w_rxTicksNext;
            r_rxBits  <= w_rxBitsNext;
            r_rxShift <= w_rxShiftNext;
        end
    end

    // Start is confirmed mid-bit (8 ticks in); every later sample lands 16 ticks apart.
    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxTicksNext = r_rxTicks;
        w_rxBitsNext  = r_rxBits;
        w_rxShiftNext = r_rxShift;
        w_rxPush      = 1'b0;
        w_rxStopBad   = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                w_rxTicksNext = 4'd0;
                if (w_rxFall) w_rxStateNext = RX_START;
            end
            RX_START: if (w_tick) begin
                w_rxTicksNext = r_rxTicks + 4'd1;
                if (r_rxTicks == 4'd7) begin
                    w_rxTicksNext = 4'd0;
                    w_rxBitsNext  = 3'd0;
                    w_rxStateNext = w_rxIn ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: if (w_tick) begin
                w_rxTicksNext = r_rxTicks + 4'd1;
                if (r_rxTicks == 4'd15) begin
                    w_rxShiftNext = {w_rxIn, r_rxShift[7:1]};
                    w_rxBitsNext  = r_rxBits + 3'd1;
                    if (r_rxBits == 3'd7) w_rxStateNext = RX_STOP;
                end
            end
            RX_STOP: if (w_tick) begin
                w_rxTicksNext = r_rxTicks + 4'd1;
                if (r_rxTicks == 4'd15) begin
                    w_rxPush      = 1'b1;
                    w_rxStopBad   = ~w_rxIn;
                    w_rxStateNext = RX_IDLE;
                end
            end
            default: w_rxStateNext = RX_IDLE;
        endcase
    end

    // A new error event wins over an LSR read landing in the same cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_oe <= 1'b0;
            r_fe <= 1'b0;
        end else begin
            if (w_rxPush && w_rxFull && !w_rbrRead) r_oe <= 1'b1;
            else if (w_lsrRead)                     r_oe <= 1'b0;
            if (w_rxPush && w_rxStopBad)            r_fe <= 1'b1;
            else if (w_lsrRead)                     r_fe <= 1'b0;
        end
    end

    always_comb begin
        if ((r_oe | r_fe) & r_ier[IER_RLS])
            w_iir = IIR_RLS;
        else if (~w_rxEmpty & r_ier[IER_RDA])
            w_iir = IIR_RDA;
        else if (w_txEmpty & ~r_threMask & r_ier[IER_THRE])
            w_iir = IIR_THRE;
        else
            w_iir = IIR_NONE;
    end

    always_comb begin
        w_lsr           = 8'h00;
        w_lsr[LSR_DR]   = ~w_rxEmpty;
        w_lsr[LSR_OE]   = r_oe;
        w_lsr[LSR_FE]   = r_fe;
        w_lsr[LSR_THRE] = w_txEmpty;
        w_lsr[LSR_TEMT] = w_txEmpty & (r_txState == TX_IDLE);
    end

    assign w_msr = w_loop ? {r_mcr[3], r_mcr[2], r_mcr[0], r_mcr[1], 4'h0}
                          : {~dcd_pad_i, ~ri_pad_i, ~dsr_pad_i, ~cts_pad_i, 4'h0};

    always_comb begin
        w_rdByte = 8'h00;
        case (w_adr)
            REG_RBR: w_rdByte = w_dlab ? r_dll : (w_rxEmpty ? 8'h00 : w_rxData);
            REG_IER: w_rdByte = w_dlab ? r_dlm : {5'b00000, r_ier};
            REG_IIR: w_rdByte = w_iir;
            REG_LCR: w_rdByte = r_lcr;
            REG_MCR: w_rdByte = {3'b000, r_mcr};
            REG_LSR: w_rdByte = w_lsr;
            REG_MSR: w_rdByte = w_msr;
            REG_SCR: w_rdByte = r_scr;
            default: w_rdByte = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_int <= 1'b0;
        else          r_int <= (w_iir != IIR_NONE);
    end

    assign int_o     = r_int;
    assign stx_pad_o = w_loop ? 1'b1 : r_txLine;
    assign rts_pad_o = w_loop ? 1'b1 : ~r_mcr[1];
    assign dtr_pad_o = w_loop ? 1'b1 : ~r_mcr[0];

endmodule

// File: tb/tb_wb_uart_lite.sv
// Directed bench for wb_uart_lite: register access, TX framing, loopback
// receive, overrun reporting and reset behaviour, with hand-computed expectations.
module tb_wb_uart_lite;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wbAdr;
    logic [31:0] wbDatI;
    logic [31:0] wbDatO;
    logic        wbWe;
    logic        wbStb;
    logic        wbCyc;
    logic [3:0]  wbSel;
    logic        wbAck;
    logic        intO;
    logic        stx;
    logic        srx;
    logic        rts;
    logic        cts;
    logic        dtr;
    logic        dsr;
    logic        ri;
    logic        dcd;

    int testsRun    = 0;
    int testsFailed = 0;
    int ackErrors   = 0;

    always #5 clk = ~clk;

    wb_uart_lite #(.FIFO_DEPTH(16), .DIV_RESET(0)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (wbAdr),
        .wb_dat_i  (wbDatI),
        .wb_dat_o  (wbDatO),
        .wb_we_i   (wbWe),
        .wb_stb_i  (wbStb),
        .wb_cyc_i  (wbCyc),
        .wb_sel_i  (wbSel),
        .wb_ack_o  (wbAck),
        .int_o     (intO),
        .stx_pad_o (stx),
        .srx_pad_i (srx),
        .rts_pad_o (rts),
        .cts_pad_i (cts),
        .dtr_pad_o (dtr),
        .dsr_pad_i (dsr),
        .ri_pad_i  (ri),
        .dcd_pad_i (dcd)
    );

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One wishbone access; ack must be low before, high for the one cycle after, then low again.
    task automatic applyStimulus(input logic [2:0] adr, input logic we, input logic [7:0] wdata,
                                 output logic [31:0] rdata);
        @(negedge clk);
        wbAdr  = {2'b00, adr};
        wbDatI = {24'h0, wdata};
        wbWe   = we;
        wbSel  = 4'h1;
        wbCyc  = 1'b1;
        wbStb  = 1'b1;
        if (wbAck !== 1'b0) ackErrors++;
        @(posedge clk); #1;
        if (wbAck !== 1'b1) ackErrors++;
        rdata = wbDatO;
        @(posedge clk); #1;
        wbCyc = 1'b0;
        wbStb = 1'b0;
        wbWe  = 1'b0;
        if (wbAck !== 1'b0) ackErrors++;
    endtask

    task automatic writeReg(input logic [2:0] adr, input logic [7:0] data);
        logic [31:0] dummy;
        applyStimulus(adr, 1'b1, data, dummy);
    endtask

    task automatic readReg(input logic [2:0] adr, output logic [31:0] data);
        applyStimulus(adr, 1'b0, 8'h00, data);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Polls for stx going low within a cycle budget.
    task automatic waitStartBit(input int budget, output int found);
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (stx == 1'b0) begin
                found = 1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          found;
        int          lowLen;
        int          sawLow;
        int          gotIrq;
        logic [7:0]  bits;
        logic        stopBit;

        rst    = 1'b1;
        wbAdr  = 5'd0;
        wbDatI = 32'h0;
        wbWe   = 1'b0;
        wbStb  = 1'b0;
        wbCyc  = 1'b0;
        wbSel  = 4'h0;
        srx    = 1'b1;
        cts    = 1'b1;
        dsr    = 1'b0;
        ri     = 1'b1;
        dcd    = 1'b0;

        waitCycles(3);
        checkOutput("rst_ack", 32'(wbAck), 32'd0);
        checkOutput("rst_stx", 32'(stx), 32'd1);
        checkOutput("rst_int", 32'(intO), 32'd0);
        checkOutput("rst_rts", 32'(rts), 32'd1);
        checkOutput("rst_dtr", 32'(dtr), 32'd1);
        rst = 1'b0;

        readReg(3'd5, d); checkOutput("rst_lsr", d, 32'h60);
        readReg(3'd2, d); checkOutput("rst_iir", d, 32'h01);
        readReg(3'd6, d); checkOutput("rst_msr", d, 32'hA0);
        readReg(3'd3, d); checkOutput("rst_lcr", d, 32'h00);
        readReg(3'd1, d); checkOutput("rst_ier", d, 32'h00);
        readReg(3'd4, d); checkOutput("rst_mcr", d, 32'h00);
        readReg(3'd7, d); checkOutput("rst_scr", d, 32'h00);

        writeReg(3'd3, 8'h80);
        writeReg(3'd0, 8'h02);
        writeReg(3'd1, 8'h00);
        readReg(3'd0, d); checkOutput("dll", d, 32'h02);
        readReg(3'd1, d); checkOutput("dlm", d, 32'h00);
        readReg(3'd3, d); checkOutput("lcr_dlab", d, 32'h80);
        writeReg(3'd3, 8'h03);
        readReg(3'd3, d); checkOutput("lcr", d, 32'h03);
        writeReg(3'd7, 8'hA5);
        readReg(3'd7, d); checkOutput("scr", d, 32'hA5);
        readReg(3'd0, d); checkOutput("rbr_empty", d, 32'h00);
        checkOutput("ack_timing", 32'(ackErrors), 32'd0);

        writeReg(3'd1, 8'h02);
        waitCycles(2);
        checkOutput("thre_int", 32'(intO), 32'd1);
        readReg(3'd2, d); checkOutput("iir_thre", d, 32'h02);
        waitCycles(2);
        readReg(3'd2, d); checkOutput("iir_thre_masked", d, 32'h01);
        checkOutput("thre_int_drop", 32'(intO), 32'd0);
        writeReg(3'd1, 8'h00);

        writeReg(3'd0, 8'h55);
        waitStartBit(200, found);
        checkOutput("tx_start_seen", 32'(found), 32'd1);
        lowLen = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stx == 1'b0) lowLen++;
            else break;
        end
        checkOutput("tx_bit_clocks", 32'(lowLen), 32'd32);
        waitCycles(16);
        for (int k = 0; k < 8; k++) begin
            bits[k] = stx;
            waitCycles(32);
        end
        stopBit = stx;
        checkOutput("tx_data_bits", 32'(bits), 32'h55);
        checkOutput("tx_stop_bit", 32'(stopBit), 32'd1);
        readReg(3'd5, d); checkOutput("lsr_in_stop", d, 32'h20);
        waitCycles(40);
        readReg(3'd5, d); checkOutput("lsr_tx_done", d, 32'h60);

        writeReg(3'd4, 8'h13);
        checkOutput("lb_rts", 32'(rts), 32'd1);
        checkOutput("lb_dtr", 32'(dtr), 32'd1);
        readReg(3'd6, d); checkOutput("lb_msr", d, 32'h30);
        writeReg(3'd1, 8'h01);
        writeReg(3'd0, 8'hC3);
        sawLow = 0;
        gotIrq = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (stx == 1'b0) sawLow = 1;
            if (intO == 1'b1) begin
                gotIrq = 1;
                break;
            end
        end
        checkOutput("lb_irq", 32'(gotIrq), 32'd1);
        checkOutput("lb_stx_held", 32'(sawLow), 32'd0);
        readReg(3'd2, d); checkOutput("lb_iir_rda", d, 32'h04);
        readReg(3'd5, d); checkOutput("lb_lsr_dr", d & 32'h01, 32'h01);
        readReg(3'd0, d); checkOutput("lb_rbr", d, 32'hC3);
        waitCycles(2);
        checkOutput("lb_int_drop", 32'(intO), 32'd0);

        writeReg(3'd1, 8'h05);
        writeReg(3'd0, 8'h80);
        waitCycles(40);
        for (int i = 1; i <= 16; i++) writeReg(3'd0, 8'(i));
        waitCycles(5800);
        readReg(3'd2, d); checkOutput("ovr_iir", d, 32'h06);
        readReg(3'd5, d); checkOutput("ovr_lsr", d, 32'h63);
        readReg(3'd5, d); checkOutput("ovr_lsr_cleared", d, 32'h61);
        readReg(3'd2, d); checkOutput("ovr_iir_after", d, 32'h04);
        readReg(3'd0, d); checkOutput("ovr_first_byte", d, 32'h80);
        readReg(3'd0, d); checkOutput("ovr_second_byte", d, 32'h01);
        writeReg(3'd2, 8'h02);
        readReg(3'd5, d); checkOutput("fcr_rx_clear", d, 32'h60);

        writeReg(3'd1, 8'h00);
        writeReg(3'd4, 8'h00);
        writeReg(3'd0, 8'h5A);
        waitStartBit(200, found);
        checkOutput("rst_mid_start", 32'(found), 32'd1);
        waitCycles(50);
        checkOutput("rst_mid_low", 32'(stx), 32'd0);
        rst = 1'b1;
        #2;
        checkOutput("rst_mid_stx", 32'(stx), 32'd1);
        waitCycles(2);
        rst = 1'b0;
        readReg(3'd5, d); checkOutput("rst_mid_lsr", d, 32'h60);
        readReg(3'd0, d); checkOutput("rst_mid_rbr", d, 32'h00);

        writeReg(3'd0, 8'h41);
        sawLow = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (stx == 1'b0) sawLow = 1;
        end
        checkOutput("div0_no_tx", 32'(sawLow), 32'd0);
        readReg(3'd5, d); checkOutput("div0_lsr", d, 32'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
